store_pack_buffer: RTL and testbench
====================================

Name: store_pack_buffer

Overview:
- Store-side counterpart of the load/immediate extension path in the MIPS datapath. It narrows and packs register data for SB/SH/SW.
- Generates byte strobes and word-aligned addresses, detects misaligned stores (AdES), and queues accepted stores in a small FIFO.
- The FIFO drains to data memory over a req/ack handshake.
- Sits between the MEM stage and the data-memory port.

Parameters:
DEPTH, 2, number of store entries buffered (power of two, 2..8)
AW, 32, address width

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
st_valid  in  1  store request from MEM stage
st_ready  out  1  buffer can accept a store this cycle
st_opcode  in  6  instruction opcode: 101000 SB, 101001 SH, 101011 SW
st_addr  in  AW  byte address
st_wdata  in  32  rt register value
st_ades  out  1  one-cycle pulse: misaligned store rejected
st_badvaddr  out  AW  faulting address, valid with st_ades
mem_req  out  1  head entry valid toward memory
mem_ack  in  1  memory accepted head entry
mem_addr  out  AW  word address {addr[AW-1:2],2'b00}
mem_wdata  out  32  packed write data
mem_wstrb  out  4  byte write enables
buf_count  out  clog2(DEPTH)+1  occupied entries
buf_empty  out  1  buf_count==0

Behaviour:
- Reset (async, resetn=0): all entries invalid; buf_count=0; buf_empty=1; mem_req=0; mem_addr/mem_wdata/mem_wstrb=0; st_ades=0; st_badvaddr=0; st_ready=1 once resetn=1.
- Packing is combinational on the inputs; the result is registered into the FIFO tail on accept.
- SB: wdata={4{st_wdata[7:0]}}; wstrb=4'b0001<<addr[1:0]. Never misaligned.
- SH: wdata={2{st_wdata[15:0]}}; wstrb=addr[1]?4'b1100:4'b0011. Misaligned if addr[0]=1.
- SW: wdata=st_wdata; wstrb=4'b1111. Misaligned if addr[1:0]!=0.
- Any other opcode: accepted and dropped. No enqueue, no ades.
- Accept condition: accept = st_valid & st_ready.
- st_ready = (buf_count<DEPTH). It is registered-count based; a pop in the same cycle does not raise st_ready when full.
- On an accepted, misaligned store: not enqueued. st_ades=1 and st_badvaddr=st_addr on the next cycle, for exactly one cycle. Otherwise st_ades=0 and st_badvaddr holds its last value.
- Output side:
  - mem_req=!buf_empty; mem_addr/mem_wdata/mem_wstrb come from the head entry and are held stable while mem_req=1 & mem_ack=0.
  - Pop when mem_req & mem_ack. mem_ack while mem_req=0 is ignored.
- FIFO:
  - Circular head/tail pointers of clog2(DEPTH) bits wrap modulo DEPTH.
  - Same-cycle push and pop: count unchanged; both pointers advance.
  - Entries drain in program order. Minimum latency from accept to mem_req=1 is 1 cycle (empty buffer).
- Reset mid-operation: pending entries discarded; mem_req drops asynchronously.

Optional Feature:
STORE_FORWARD_EN
- Defined:
  - Adds inputs ld_valid(1) and ld_addr(AW), and output ld_conflict(1).
  - ld_conflict=1 combinationally when ld_valid=1 and any valid entry, or the store accepted this cycle, has the same word address (addr[AW-1:2]) with an overlapping strobe. For a load, the strobe is treated as 4'b1111.
  - The pipeline stalls the load while ld_conflict=1.
- Undefined: these ports do not exist; loads never check the buffer.

Test Plan:
- Reset then SB addr=0x1003 wdata=0x123456AB, mem_ack=1 -> next cycle mem_req=1, mem_addr=0x1000, mem_wdata=0xABABABAB, mem_wstrb=1000; one cycle later buf_empty=1.
- SH addr=0x2002 wdata=0x0000BEEF -> mem_wdata=0xBEEFBEEF, mem_wstrb=1100. SH addr=0x2001 -> st_ades=1 for 1 cycle, st_badvaddr=0x2001, buf_count unchanged.
- mem_ack=0, three SW (0x10,0x14,0x18), DEPTH=2 -> first two accepted, st_ready=0 on third. Raise mem_ack -> outputs 0x10 then 0x14 in order, with data stable while not acked; third accepted after the first pop.
- Buffer holding 1 entry, simultaneous accept and mem_ack -> buf_count stays 1; pointers wrap correctly over 5 consecutive stores.
- Two entries queued, resetn=0 mid-cycle -> mem_req=0 immediately; after release buf_empty=1 and st_ready=1.
- STORE_FORWARD_EN: SW to 0x40 queued with mem_ack=0, ld_valid=1 ld_addr=0x42 -> ld_conflict=1; ld_addr=0x44 -> ld_conflict=0.

Source files
------------

// File: rtl/store_pack_buffer.sv
// store_pack_buffer: packs SB/SH/SW data into word writes with byte strobes, raises AdES on misaligned stores, and queues stores toward data memory (define STORE_FORWARD_EN for load-conflict detection)
module store_pack_buffer #(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [5:0]               st_opcode,
  input  logic [AW-1:0]            st_addr,
  input  logic [31:0]              st_wdata,
  output logic                     st_ades,
  output logic [AW-1:0]            st_badvaddr,
  output logic                     mem_req,
  input  logic                     mem_ack,
  output logic [AW-1:0]            mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_wstrb,
  output logic [$clog2(DEPTH):0]   buf_count,
  output logic                     buf_empty
`ifdef STORE_FORWARD_EN
  ,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_conflict
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0]   count_q;
  logic [AW-3:0] addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    strb_q [DEPTH];
  logic          ades_q;
  logic [AW-1:0] badv_q;
  logic          is_sb, is_sh, is_sw, mis, accept, push, pop;
  logic [31:0]   pk_data;
  logic [3:0]    pk_strb;
  // decode the opcode and replicate/steer the store data into its byte lanes
  always_comb begin
    is_sb   = st_opcode == 6'b101000;
    is_sh   = st_opcode == 6'b101001;
    is_sw   = st_opcode == 6'b101011;
    mis     = (is_sh & st_addr[0]) | (is_sw & |st_addr[1:0]);
    pk_data = is_sb ? {4{st_wdata[7:0]}} : is_sh ? {2{st_wdata[15:0]}} : st_wdata;
    pk_strb = is_sb ? 4'b0001 << st_addr[1:0] : is_sh ? (st_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    accept  = st_valid & st_ready;
    push    = accept & (is_sb | is_sh | is_sw) & ~mis;
    pop     = mem_req & mem_ack;
  end
  assign st_ready    = count_q != FULL;
  assign mem_req     = count_q != '0;
  assign buf_empty   = count_q == '0;
  assign buf_count   = count_q;
  assign mem_addr    = {addr_q[head_q], 2'b00};
  assign mem_wdata   = data_q[head_q];
  assign mem_wstrb   = strb_q[head_q];
  assign st_ades     = ades_q;
  assign st_badvaddr = badv_q;
  // circular FIFO: write at tail on push, advance head on pop
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        strb_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail_q] <= st_addr[AW-1:2];
        data_q[tail_q] <= pk_data;
        strb_q[tail_q] <= pk_strb;
        tail_q         <= tail_q + PW'(1);
      end
      if (pop) head_q <= head_q + PW'(1);
      count_q <= count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end
  // one-cycle AdES pulse; the faulting address is held until the next fault
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ades_q <= 1'b0;
      badv_q <= '0;
    end else begin
      ades_q <= accept & mis;
      if (accept & mis) badv_q <= st_addr;
    end
  end
`ifdef STORE_FORWARD_EN
  logic [DEPTH-1:0] valid_q;
  // per-entry occupancy, used only to qualify load address matches
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) valid_q <= '0;
    else begin
      if (pop) valid_q[head_q] <= 1'b0;
      if (push) valid_q[tail_q] <= 1'b1;
    end
  end
  // a load is treated as a full-word access, so any live strobe on the same word conflicts
  always_comb begin
    ld_conflict = ld_valid & push & (st_addr[AW-1:2] == ld_addr[AW-1:2]);
    for (int i = 0; i < DEPTH; i++)
      ld_conflict = ld_conflict | (ld_valid & valid_q[i] & (addr_q[i] == ld_addr[AW-1:2]) & |strb_q[i]);
  end
`endif
endmodule

// File: tb/tb_store_pack_buffer.sv
// tb_store_pack_buffer: directed stimulus with a scoreboard queue checked by an independent memory-side monitor
module tb_store_pack_buffer;
  localparam logic [5:0] SB = 6'b101000, SH = 6'b101001, SW = 6'b101011, LW = 6'b100011;
  logic        clk = 0, resetn = 0, st_valid = 0, st_ready, st_ades, mem_req, mem_ack = 0, buf_empty;
  logic [5:0]  st_opcode = 0;
  logic [31:0] st_addr = 0, st_wdata = 0, st_badvaddr, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  buf_count;
  int total = 0, bad = 0;
  logic [67:0] exp_q[$];
  logic [31:0] ades_q[$];
  logic        hold_prev = 0, ades_prev = 0;
  logic [67:0] held;
`ifdef STORE_FORWARD_EN
  logic        ld_valid = 0, ld_conflict;
  logic [31:0] ld_addr = 0;
`endif
  store_pack_buffer #(.DEPTH(2), .AW(32)) dut (
    .clk(clk), .resetn(resetn), .st_valid(st_valid), .st_ready(st_ready),
    .st_opcode(st_opcode), .st_addr(st_addr), .st_wdata(st_wdata),
    .st_ades(st_ades), .st_badvaddr(st_badvaddr), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .buf_count(buf_count), .buf_empty(buf_empty)
`ifdef STORE_FORWARD_EN
    , .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict)
`endif
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // memory-side monitor: pops the scoreboard on each handshake, checks hold stability and AdES pulses
  always @(negedge clk) begin
    if (!resetn) begin
      hold_prev = 0;
      ades_prev = 0;
    end else begin
      if (hold_prev && mem_req) chk("hold_stable", {mem_addr, mem_wdata, mem_wstrb}, held);
      hold_prev = mem_req && !mem_ack;
      held = {mem_addr, mem_wdata, mem_wstrb};
      if (mem_req && mem_ack) begin
        if (exp_q.size() == 0) chk("unexpected_mem_req", 1, 0);
        else chk("mem_out", {mem_addr, mem_wdata, mem_wstrb}, exp_q.pop_front());
      end
      if (st_ades) begin
        if (ades_q.size() == 0) chk("unexpected_ades", 1, 0);
        else chk("badvaddr", st_badvaddr, ades_q.pop_front());
        if (ades_prev) chk("ades_one_cycle", 1, 0);
      end
      ades_prev = st_ades;
    end
  end

  task automatic do_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                          input bit push, input bit ades, input logic [67:0] e);
    int n = 0;
    st_valid = 1; st_opcode = op; st_addr = a; st_wdata = d;
    while (!st_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n == 50) chk("st_ready_timeout", 0, 1);
    if (push) exp_q.push_back(e);
    if (ades) ades_q.push_back(a);
    @(posedge clk); #1;
    st_valid = 0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (!buf_empty && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n == 50) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #12;
    chk("rst_state", {mem_req, buf_count, buf_empty, st_ades, st_badvaddr}, {1'b0, 2'd0, 1'b1, 1'b0, 32'h0});
    chk("rst_mem_out", {mem_addr, mem_wdata, mem_wstrb}, 68'h0);
    @(negedge clk); resetn = 1;
    @(posedge clk); #1;
    chk("rst_ready", st_ready, 1);
    // SB at the top byte lane, drains the cycle after it appears
    mem_ack = 1;
    do_store(SB, 32'h1003, 32'h123456AB, 1, 0, {32'h1000, 32'hABABABAB, 4'b1000});
    chk("sb_latency_req", mem_req, 1);
    @(posedge clk); #1;
    chk("sb_drained", buf_empty, 1);
    // halfword lanes and misaligned rejects
    do_store(SH, 32'h2002, 32'h0000BEEF, 1, 0, {32'h2000, 32'hBEEFBEEF, 4'b1100});
    do_store(SH, 32'h2004, 32'h0000CAFE, 1, 0, {32'h2004, 32'hCAFECAFE, 4'b0011});
    do_store(SB, 32'h2005, 32'h0000005A, 1, 0, {32'h2004, 32'h5A5A5A5A, 4'b0010});
    wait_empty();
    do_store(SH, 32'h2001, 32'h0000BEEF, 0, 1, '0);
    chk("sh_mis_ades", st_ades, 1);
    chk("sh_mis_count", buf_count, 0);
    @(posedge clk); #1;
    chk("ades_cleared", st_ades, 0);
    chk("badv_held", st_badvaddr, 32'h2001);
    do_store(SW, 32'h3002, 32'hDEADBEEF, 0, 1, '0);
    chk("sw_mis_count", buf_count, 0);
    do_store(LW, 32'h3000, 32'h11111111, 0, 0, '0);
    chk("other_op_dropped", {st_ades, buf_count}, 3'b000);
    // fill with memory stalled, then release
    mem_ack = 0;
    do_store(SW, 32'h10, 32'h11111111, 1, 0, {32'h10, 32'h11111111, 4'hF});
    do_store(SW, 32'h14, 32'h22222222, 1, 0, {32'h14, 32'h22222222, 4'hF});
    chk("full_count", buf_count, 2);
    chk("full_not_ready", st_ready, 0);
`ifdef STORE_FORWARD_EN
    ld_valid = 1; ld_addr = 32'h12; #1;
    chk("ld_conflict_hit", ld_conflict, 1);
    ld_addr = 32'h1C; #1;
    chk("ld_conflict_miss", ld_conflict, 0);
    ld_valid = 0;
`endif
    fork
      do_store(SW, 32'h18, 32'h33333333, 1, 0, {32'h18, 32'h33333333, 4'hF});
      begin repeat (3) @(posedge clk); #2 mem_ack = 1; end
    join
    wait_empty();
    // one resident entry, simultaneous push and pop keep the count steady across pointer wraps
    mem_ack = 0;
    do_store(SW, 32'h100, 32'hA0, 1, 0, {32'h100, 32'hA0, 4'hF});
    mem_ack = 1;
    for (int i = 1; i <= 5; i++) begin
      logic [31:0] a;
      a = 32'h100 + 32'(i) * 4;
      do_store(SW, a, 32'hA0 + 32'(i), 1, 0, {a, 32'hA0 + 32'(i), 4'hF});
      chk("pushpop_count", buf_count, 1);
    end
    wait_empty();
`ifdef STORE_FORWARD_EN
    mem_ack = 0;
    do_store(SW, 32'h40, 32'h44444444, 1, 0, {32'h40, 32'h44444444, 4'hF});
    ld_valid = 1; ld_addr = 32'h42; #1;
    chk("fwd_conflict_42", ld_conflict, 1);
    ld_addr = 32'h44; #1;
    chk("fwd_conflict_44", ld_conflict, 0);
    ld_valid = 0; mem_ack = 1;
    wait_empty();
`endif
    // asynchronous reset with entries pending
    mem_ack = 0;
    do_store(SW, 32'h200, 32'h55555555, 0, 0, '0);
    do_store(SW, 32'h204, 32'h66666666, 0, 0, '0);
    chk("pre_reset_count", buf_count, 2);
    #3 resetn = 0;
    #1 chk("async_req_drop", mem_req, 0);
    @(negedge clk); resetn = 1;
    @(posedge clk); #1;
    chk("post_reset", {buf_empty, st_ready, mem_req}, 3'b110);
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("ades_queue_empty", ades_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
